// File: rtl/debug_pkg.sv
// Shared constants, FSM state type and payload layout for the debug packetiser.
package debug_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam logic [7:0] PKT_TYPE_EVT  = 8'h01;
  localparam logic [7:0] PKT_TYPE_SNAP = 8'h02;

  localparam int unsigned EVT_LEN   = 7;
  localparam int unsigned SNAP_LEN  = 11;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned PAYLOAD_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // pc sits in the low bits so an LSB-first shift emits pc before instruction
  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
  } snap_payload_t;

endpackage

// File: rtl/debug_tick_gen.sv
// Periodic tick source: counts TICK_DIV cycles while enabled, held at zero by clr.
module debug_tick_gen #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick_c = en && !clr && (cnt == CNT_W'(TICK_DIV - 1));

  // Counter wraps on the tick edge
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (tick_c) cnt <= '0;
      else        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/debug_tx_sequencer.sv
// Frames debug events and periodic PC/instruction snapshots onto a byte stream.
module debug_tx_sequencer
  import debug_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned SNAP_HZ  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic [31:0] debug_data,
  input  logic        debug_valid,
  input  logic        enable,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  drop_count
);

  localparam int unsigned TICK_RAW = CLK_FREQ / SNAP_HZ;
  localparam int unsigned TICK_DIV = (TICK_RAW < 2) ? 2 : TICK_RAW;

  state_t                 state, state_nxt;
  logic [PAYLOAD_W-1:0]   shift, shift_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic                   is_snap, is_snap_nxt;
  logic [7:0]             chk, chk_nxt;
  logic [7:0]             tx_data_nxt;
  logic                   tx_valid_nxt;
  logic                   evt_start_c, snap_start_c;

  logic [31:0]            evt_word;
  logic                   evt_pending, snap_pending;
  logic                   tick_c, evt_cap_c, drop_c;
  logic [IDX_W-1:0]       last_idx_c, idx_inc_c;
  snap_payload_t          snap_c;

  debug_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (enable),
    .clr    (!enable),
    .tick_c (tick_c)
  );

  assign snap_c     = '{instruction: instruction, pc: pc};
  assign last_idx_c = is_snap ? IDX_W'(SNAP_LEN - 1) : IDX_W'(EVT_LEN - 1);
  assign idx_inc_c  = idx + IDX_W'(1);
  assign evt_cap_c  = enable && debug_valid && (!evt_pending || evt_start_c);
  assign drop_c     = enable && debug_valid && evt_pending && !evt_start_c;

  // Next-state and byte-stream logic
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift;
    idx_nxt      = idx;
    is_snap_nxt  = is_snap;
    chk_nxt      = chk;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = tx_valid;
    evt_start_c  = 1'b0;
    snap_start_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && (evt_pending || snap_pending)) begin
          state_nxt    = SEND;
          idx_nxt      = '0;
          chk_nxt      = '0;
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = SYNC_BYTE;
          if (evt_pending) begin
            evt_start_c = 1'b1;
            is_snap_nxt = 1'b0;
            shift_nxt   = {32'h0, evt_word};
          end else begin
            snap_start_c = 1'b1;
            is_snap_nxt  = 1'b1;
            shift_nxt    = snap_c;
          end
        end
      end
      SEND: begin
        if (tx_valid && tx_ready) begin
          if (idx == last_idx_c) begin
            state_nxt    = IDLE;
            tx_valid_nxt = 1'b0;
            idx_nxt      = '0;
          end else begin
            idx_nxt = idx_inc_c;
            if (idx == '0) begin
              tx_data_nxt = is_snap ? PKT_TYPE_SNAP : PKT_TYPE_EVT;
              chk_nxt     = is_snap ? PKT_TYPE_SNAP : PKT_TYPE_EVT;
            end else if (idx_inc_c == last_idx_c) begin
              tx_data_nxt = chk;
            end else begin
              tx_data_nxt = shift[7:0];
              chk_nxt     = chk ^ shift[7:0];
              shift_nxt   = shift >> 8;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM and transmit registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      idx      <= '0;
      is_snap  <= 1'b0;
      chk      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      shift    <= shift_nxt;
      idx      <= idx_nxt;
      is_snap  <= is_snap_nxt;
      chk      <= chk_nxt;
      tx_data  <= tx_data_nxt;
      tx_valid <= tx_valid_nxt;
      busy     <= (state_nxt == SEND);
    end
  end

  // Event buffer, drop counter and snapshot request; a new tick wins over a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_word     <= '0;
      evt_pending  <= 1'b0;
      snap_pending <= 1'b0;
      drop_count   <= '0;
    end else begin
      if (evt_cap_c) begin
        evt_word    <= debug_data;
        evt_pending <= 1'b1;
      end else if (evt_start_c) begin
        evt_pending <= 1'b0;
      end
      if (drop_c && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
      if (tick_c)            snap_pending <= 1'b1;
      else if (snap_start_c) snap_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debug_tx_sequencer.sv
// Scoreboard bench: a packet-level model predicts the byte stream, a monitor checks it.
module tb_debug_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, instruction, debug_data;
  logic        debug_valid, enable, tx_ready;
  logic [7:0]  tx_data, drop_count;
  logic        tx_valid, busy;

  int n_tests = 0;
  int n_fail  = 0;

  debug_tx_sequencer #(.CLK_FREQ(1000), .SNAP_HZ(100)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .instruction (instruction),
    .debug_data  (debug_data),
    .debug_valid (debug_valid),
    .enable      (enable),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  exp_q[$];
  int          m_left;     // bytes of the current packet not yet transferred
  bit          m_evt_p, m_snap_p, m_start;
  logic [31:0] m_evt_w;
  int          m_cnt, m_drops;

  task automatic push_pkt(input logic [7:0] typ, input logic [63:0] pl, input int n);
    logic [7:0] c;
    logic [7:0] b;
    c = typ;
    exp_q.push_back(8'hA5);
    exp_q.push_back(typ);
    for (int i = 0; i < n; i++) begin
      b = pl[8*i +: 8];
      exp_q.push_back(b);
      c = c ^ b;
    end
    exp_q.push_back(c);
  endtask

  // Model advances on each active edge using the inputs presented before it
  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_evt_p = 0; m_snap_p = 0; m_cnt = 0; m_drops = 0; m_evt_w = '0;
      exp_q.delete();
    end else begin
      m_start = (m_left == 0) && enable && (m_evt_p || m_snap_p);
      if (m_left > 0 && tx_ready) m_left--;
      if (m_start) begin
        if (m_evt_p) begin
          push_pkt(8'h01, {32'h0, m_evt_w}, 4);
          m_left  = 7;
          m_evt_p = 0;
        end else begin
          push_pkt(8'h02, {instruction, pc}, 8);
          m_left   = 11;
          m_snap_p = 0;
        end
      end
      if (enable) begin
        if (m_cnt == 9) begin m_cnt = 0; m_snap_p = 1; end
        else m_cnt++;
      end else begin
        m_cnt = 0;
      end
      if (enable && debug_valid) begin
        if (!m_evt_p) begin m_evt_p = 1; m_evt_w = debug_data; end
        else if (m_drops < 255) m_drops++;
      end
    end
  end

  // ---------------- monitor ----------------
  bit         prev_stall = 0;
  logic [7:0] prev_data  = '0;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("busy", busy, (m_left > 0));
      check("tx_valid", tx_valid, (m_left > 0));
      check("drop_count", drop_count, m_drops);
      if (prev_stall) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", tx_data, 32'hFFFF_FFFF);
        end else begin
          exp_b = exp_q.pop_front();
          check("byte", tx_data, exp_b);
        end
      end
    end
    prev_stall = tx_valid && !tx_ready && (rst === 1'b0);
    prev_data  = tx_data;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_busy();
    int k;
    k = 0;
    while (!busy && k < 100) begin
      step(1);
      k++;
    end
    check("wait_busy", busy, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; enable = 0; tx_ready = 0; debug_valid = 0;
    debug_data = '0; pc = '0; instruction = '0;
    step(3);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_count, 0);
    rst = 0;

    // single event and its latency
    enable = 1; tx_ready = 1; pc = 32'h10; instruction = 32'h13;
    debug_valid = 1; debug_data = 32'h1234_5678;
    step(1);
    debug_valid = 0;
    step(1);
    check("latency_valid", tx_valid, 1);
    check("latency_sync", tx_data, 8'hA5);
    step(20);

    // periodic snapshots only
    step(40);

    // stall mid-packet
    debug_valid = 1; debug_data = 32'hCAFE_F00D;
    step(1);
    debug_valid = 0;
    wait_busy();
    step(3);
    tx_ready = 0;
    step(5);
    tx_ready = 1;
    step(30);

    // buffer full while link stalled, then saturate drops
    tx_ready = 0;
    for (int i = 0; i < 3; i++) begin
      debug_valid = 1; debug_data = 32'hA000_0000 + i;
      step(1);
      debug_valid = 0;
      step(2);
    end
    debug_valid = 1;
    for (int i = 0; i < 300; i++) begin
      debug_data = $urandom;
      step(1);
    end
    debug_valid = 0;
    check("drop_saturated", drop_count, 8'hFF);
    tx_ready = 1;
    step(60);

    // reset in the middle of a packet
    wait_busy();
    step(4);
    rst = 1;
    step(1);
    rst = 0;
    check("rst_mid_valid", tx_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_drop", drop_count, 0);
    step(2);
    check("no_resume", tx_valid, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      debug_valid = ($urandom_range(0, 5) == 0);
      debug_data  = $urandom;
      pc          = $urandom;
      instruction = $urandom;
      tx_ready    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      rst         = ($urandom_range(0, 799) == 0);
      step(1);
    end
    rst = 0; debug_valid = 0; tx_ready = 1; enable = 0;
    step(40);
    check("drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
